mem_port_arbiter3: RTL and testbench

- Round-robin arbiter and sequencer sharing one memory port between three requesters: 0 = I-cache refill, 1 = D-cache refill, 2 = D-cache writeback.
- Drives the 2-bit select of the team's 32-bit 3:1 datapath mux, plus the memory request strobe.
- Holds a grant for the whole memory transaction and returns a per-requester completion pulse.

---
 rtl/mem_port_arbiter3.sv | 136 +++++++++++++
 tb/tb_mem_port_arbiter3.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter3.sv
// Round-robin arbiter/sequencer sharing one memory port among I-refill, D-refill and D-writeback.
// Optional BUSY watchdog is compiled in with `define ARB_WATCHDOG_EN.
//
// state | meaning
// IDLE  | no transaction; arbitrates every cycle, incl. the cycle carrying done_o
// BUSY  | grant held, mem_req_o high, waiting for mem_ack_i (or watchdog expiry)
module mem_port_arbiter3 #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 8
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [2:0] req_i,
  output logic [2:0] gnt_o,
  output logic [1:0] sel_o,
  output logic       mem_req_o,
  input  logic       mem_ack_i,
  output logic [2:0] done_o,
  output logic       busy_o,
  output logic       timeout_o
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t     state_q, state_d;
  logic [2:0] gnt_q, gnt_d;
  logic [2:0] done_q, done_d;
  logic [1:0] sel_q, sel_d;
  logic [1:0] ptr_q, ptr_d;
  logic [1:0] p0, p1, p2, win;
  logic       found;

  if (TIMEOUT < 2 || TIMEOUT > 255 || (TIMEOUT - 1) >= (1 << CNT_W)) begin : g_bad_cfg
    $error("mem_port_arbiter3: TIMEOUT must be 2..255 and fit in CNT_W bits");
  end

  function automatic logic [1:0] inc3(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Scan from the farthest candidate back so the one closest to ptr wins.
  always_comb begin
    p0    = ptr_q;
    p1    = inc3(p0);
    p2    = inc3(p1);
    win   = p0;
    found = 1'b0;
    if (req_i[p2]) begin win = p2; found = 1'b1; end
    if (req_i[p1]) begin win = p1; found = 1'b1; end
    if (req_i[p0]) begin win = p0; found = 1'b1; end
  end

`ifdef ARB_WATCHDOG_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;
`endif

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    done_d  = 3'b000;
`ifdef ARB_WATCHDOG_EN
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d = BUSY;
          gnt_d   = 3'b001 << win;
          sel_d   = win;
`ifdef ARB_WATCHDOG_EN
          cnt_d   = '0;
`endif
        end
      end
      BUSY: begin
        if (mem_ack_i) begin
          state_d = IDLE;
          gnt_d   = 3'b000;
          done_d  = gnt_q;
          ptr_d   = inc3(sel_q);
        end
`ifdef ARB_WATCHDOG_EN
        else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d   = IDLE;
          gnt_d     = 3'b000;
          timeout_d = 1'b1;
          ptr_d     = inc3(sel_q);
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      gnt_q   <= 3'b000;
      sel_q   <= 2'd0;
      ptr_q   <= 2'd0;
      done_q  <= 3'b000;
`ifdef ARB_WATCHDOG_EN
      cnt_q     <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      done_q  <= done_d;
`ifdef ARB_WATCHDOG_EN
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
`endif
    end
  end

  assign gnt_o     = gnt_q;
  assign sel_o     = sel_q;
  assign done_o    = done_q;
  assign mem_req_o = (state_q == BUSY);
  assign busy_o    = (state_q == BUSY);
`ifdef ARB_WATCHDOG_EN
  assign timeout_o = timeout_q;
`else
  assign timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter3.sv
// Directed bench for mem_port_arbiter3: grant order, hold, bubble, reset, watchdog/hold.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_mem_port_arbiter3;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic [2:0] req_i;
  logic [2:0] gnt_o;
  logic [1:0] sel_o;
  logic       mem_req_o;
  logic       mem_ack_i;
  logic [2:0] done_o;
  logic       busy_o;
  logic       timeout_o;

  int errs = 0;
  int nchk = 0;

  mem_port_arbiter3 #(.TIMEOUT(4), .CNT_W(8)) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .req_i    (req_i),
    .gnt_o    (gnt_o),
    .sel_o    (sel_o),
    .mem_req_o(mem_req_o),
    .mem_ack_i(mem_ack_i),
    .done_o   (done_o),
    .busy_o   (busy_o),
    .timeout_o(timeout_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input int obs, input int exp);
    nchk++;
    if (obs != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk_idle(input string tag, input int exp_sel, input int exp_done);
    chk({tag, " gnt"}, gnt_o, 0);
    chk({tag, " sel"}, sel_o, exp_sel);
    chk({tag, " mreq"}, mem_req_o, 0);
    chk({tag, " busy"}, busy_o, 0);
    chk({tag, " done"}, done_o, exp_done);
    chk({tag, " tmo"}, timeout_o, 0);
  endtask

  task automatic chk_grant(input string tag, input int w);
    chk({tag, " gnt"}, gnt_o, 1 << w);
    chk({tag, " sel"}, sel_o, w);
    chk({tag, " mreq"}, mem_req_o, 1);
    chk({tag, " busy"}, busy_o, 1);
    chk({tag, " done"}, done_o, 0);
  endtask

  // Entered in the first BUSY cycle of a grant to w; leaves in the done_o cycle.
  task automatic run_txn(input string tag, input int w, input int nbusy);
    chk_grant(tag, w);
    for (int i = 1; i < nbusy; i++) begin
      step();
      chk_grant({tag, " hold"}, w);
    end
    mem_ack_i = 1'b1;
    step();
    mem_ack_i = 1'b0;
    chk_idle({tag, " end"}, w, 1 << w);
  endtask

  initial begin
    rst_i = 1'b1; req_i = 3'b000; mem_ack_i = 1'b0;
    step(); step();
    chk_idle("reset", 0, 0);
    rst_i = 1'b0;

    // single requester 1; next grant from ptr=2 proves ptr update
    req_i = 3'b010;
    step();
    run_txn("r1", 1, 2);
    req_i = 3'b000;
    step();
    chk_idle("r1 after", 1, 0);

    // all requesting: ptr=2 gives order 2,0,1,2 with one bubble between grants
    req_i = 3'b111;
    step();
    run_txn("rr0", 2, 3);
    step();
    run_txn("rr1", 0, 3);
    step();
    run_txn("rr2", 1, 3);
    step();
    run_txn("rr3", 2, 3);

    // ptr=0; grant 0, then drop req0 and raise req2 mid-transaction
    req_i = 3'b001;
    step();
    chk_grant("hold g", 0);
    req_i = 3'b100;
    step(); chk_grant("hold a", 0);
    step(); chk_grant("hold b", 0);
    mem_ack_i = 1'b1;
    step();
    mem_ack_i = 1'b0;
    chk_idle("hold end", 0, 1);
    step();
    run_txn("then2", 2, 1);
    req_i = 3'b000;

    // ack while idle with no requests
    for (int i = 0; i < 3; i++) begin
      mem_ack_i = 1'b1;
      step();
      chk_idle("idle ack", 2, 0);
    end
    mem_ack_i = 1'b0;

    // ptr=0: grant 1 then complete so ptr=2, then grant 0 and reset in 2nd BUSY cycle
    req_i = 3'b010;
    step();
    run_txn("pre1", 1, 1);
    req_i = 3'b001;
    step();
    chk_grant("pre0", 0);
    step();
    chk_grant("pre0 b2", 0);
    rst_i = 1'b1;
    mem_ack_i = 1'b1;
    step();
    rst_i = 1'b0;
    mem_ack_i = 1'b0;
    chk_idle("midrst", 0, 0);
    req_i = 3'b110;
    step();
    run_txn("postrst", 1, 2);
    req_i = 3'b000;
    step();

    // ptr=2: requester 0 granted, never acked
    req_i = 3'b001;
    step();
    chk_grant("wd g", 0);
`ifdef ARB_WATCHDOG_EN
    for (int i = 0; i < 3; i++) begin
      step();
      chk_grant("wd hold", 0);
      chk("wd hold tmo", timeout_o, 0);
    end
    step();
    chk("wd tmo", timeout_o, 1);
    chk("wd gnt", gnt_o, 0);
    chk("wd done", done_o, 0);
    chk("wd busy", busy_o, 0);
    req_i = 3'b101;
    step();
    chk("wd tmo clr", timeout_o, 0);
    chk_grant("wd next", 2);
    // ack coincident with expiry is a normal completion
    step(); step(); step();
    mem_ack_i = 1'b1;
    step();
    mem_ack_i = 1'b0;
    chk_idle("wd ack", 2, 4);
`else
    repeat (100) step();
    chk_grant("nowd hold", 0);
    chk("nowd tmo", timeout_o, 0);
    mem_ack_i = 1'b1;
    step();
    mem_ack_i = 1'b0;
    chk_idle("nowd end", 0, 1);
`endif

    $display("Result: errors=%0d of %0d checks", errs, nchk);
    $finish;
  end

endmodule
